ram_dp_clr: RTL and testbench
=============================

Name: ram_dp_clr

Overview:
Parametrised simple-dual-port RAM for the graphics pipeline: one write port and one read port on a single clock. It generalises the earlier 8-bit-address/32-bit-data RAM with byte-lane write enables, a registered read with a valid flag, read-during-write forwarding and a hardware clear sequencer. The sequencer fills every word with a constant on request. It sits between the rasteriser (writer) and the VGA scan-out (reader) as the framebuffer/line store.

Parameters:
ADDR_WIDTH, 8, address bits; DEPTH = 2**ADDR_WIDTH words (full address space, no aliasing)
DATA_WIDTH, 32, word width; must be a multiple of 8 (elaboration error otherwise)
CLEAR_VALUE, 0, word written to every address by the clear sequence

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
we  in  1  write strobe
wr_addr  in  ADDR_WIDTH  write address
wr_data  in  DATA_WIDTH  write data
wr_be  in  DATA_WIDTH/8  byte enables; bit i covers wr_data[8i+7:8i]
re  in  1  read strobe
read_addr  in  ADDR_WIDTH  read address
read_data  out  DATA_WIDTH  registered read data
read_valid  out  1  high the cycle after an accepted read
clr_req  in  1  start clear sequence (sampled in IDLE only)
clr_busy  out  1  high while the clear sequence runs
clr_done  out  1  one-cycle pulse when the clear sequence completes

Behaviour:
- Reset (async assert, sync release): read_data=0, read_valid=0, clr_busy=0, clr_done=0, FSM=IDLE, clear counter=0. Memory contents are not reset.
- Write: at an edge with we=1 and FSM=IDLE, each lane i with wr_be[i]=1 updates mem[wr_addr] lane i. Lanes with wr_be[i]=0 keep their value. we=1 with wr_be=0 is a no-op.
- Read: 1-cycle latency. re=1 at edge N loads read_data with mem[read_addr], and read_valid=1 during cycle N+1. re=0: read_data holds, read_valid=0. Reads are accepted in every FSM state.
- Read-during-write, same address, same edge: read_data returns the merged new word, i.e. written lanes new and unwritten lanes old.
- FSM states: IDLE, CLEAR, DONE.
- IDLE -> CLEAR on clr_req=1; counter=0.
- CLEAR: each edge writes CLEAR_VALUE (all lanes) to mem[counter] and increments the counter. After writing DEPTH-1 -> DONE. CLEAR lasts exactly DEPTH cycles. clr_busy=1 in CLEAR only.
- DONE: clr_done=1 for one cycle, then -> IDLE.
- External writes during CLEAR or DONE are dropped silently (no queueing).
- clr_req in CLEAR or DONE is ignored.
- clr_req and we in the same IDLE cycle: the write is performed first, then the clear overwrites it.
- Read during CLEAR of the address being cleared that edge returns CLEAR_VALUE (forwarding rule applies). Addresses below the counter read CLEAR_VALUE. Addresses above the counter read old data.
- The counter is ADDR_WIDTH+1 bits internally so the terminal check never wraps ambiguously.
- rst_n asserted mid-clear: FSM returns to IDLE immediately and no clr_done pulse is produced. Memory stays partially cleared; words below the counter hold CLEAR_VALUE.

Decomposition:
- Package ram_pkg: FSM state typedef (IDLE/CLEAR/DONE), LANE_W=8 constant, function computing the number of lanes from DATA_WIDTH.
- Sub-module ram_clear_seq: FSM plus counter. Outputs clear write enable, clear address, clr_busy and clr_done. The top module muxes the write port between the external writer and the sequencer and owns the storage array and read register.

Test Plan:
- Default params. Write addr 0x10 data 0xDEADBEEF, be=4'hF; read 0x10 next cycle -> read_data=0xDEADBEEF and read_valid=1 one cycle after re.
- Write 0x10 = 0xAABBCCDD be=4'b0101 over 0xDEADBEEF -> read returns 0xDEBBBEDD.
- Same edge: we addr 0x20 data 0x12345678 be=4'hF, re addr 0x20 -> read_data=0x12345678 (forwarded).
- ADDR_WIDTH=4, CLEAR_VALUE=0x55555555. Preload all 16 words, pulse clr_req -> clr_busy high exactly 16 cycles, clr_done pulse 1 cycle, all reads then return 0x55555555. A write issued mid-clear is absent afterwards.
- ADDR_WIDTH=4: during clear, at counter=5, read addr 3 -> 0x55555555 and read addr 9 -> preloaded value. clr_req repeated mid-clear does not extend clr_busy beyond 16 cycles.
- Assert rst_n=0 at counter=7 -> outputs zero within the same cycle, no clr_done. After release, addrs 0..6 read CLEAR_VALUE, addrs 8..15 read preloaded values, and a fresh clr_req completes normally.

Source files
------------

// File: rtl/ram_pkg.sv
// ram_pkg: shared types and constants for the dual-port RAM with clear sequencer.
//   clr_state_e : clear sequencer FSM state (IDLE / CLEAR / DONE)
//   LANE_W      : width of one byte-enable lane
//   num_lanes() : number of byte lanes in a data word
package ram_pkg;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_e;

  localparam int LANE_W = 8;

  function automatic int num_lanes(input int data_width);
    return data_width / LANE_W;
  endfunction

endpackage

// File: rtl/ram_clear_seq.sv
// ram_clear_seq: walks every address once, requesting a full-word write of the
// clear value, then pulses done for one cycle.
//   clk, rst_n  : clock, asynchronous active-low reset
//   clr_req_i   : start request, only honoured in IDLE
//   clr_we_o    : write request for the storage array (CLEAR state only)
//   clr_addr_o  : address to clear this cycle
//   clr_busy_o  : high while in CLEAR
//   clr_done_o  : high for the single DONE cycle
//   state_o     : current FSM state (debug visibility)
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_req_i,
  output logic                  clr_we_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o,
  output logic                  clr_busy_o,
  output logic                  clr_done_o,
  output clr_state_e            state_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  // One extra counter bit keeps the last-address compare unambiguous.
  localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH + 1)'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH + 1)'(1);

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_o = 1'b0;
    case (state_q)
      CLR_IDLE: begin
        cnt_d = '0;
        if (clr_req_i) state_d = CLR_CLEAR;
      end
      CLR_CLEAR: begin
        clr_we_o = 1'b1;
        cnt_d    = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = CLR_DONE;
      end
      CLR_DONE: begin
        state_d = CLR_IDLE;
      end
      default: begin
        state_d = CLR_IDLE;
      end
    endcase
  end

  assign clr_addr_o = cnt_q[ADDR_WIDTH-1:0];
  assign clr_busy_o = (state_q == CLR_CLEAR);
  assign clr_done_o = (state_q == CLR_DONE);
  assign state_o    = state_q;

endmodule

// File: rtl/ram_dp_clr.sv
// ram_dp_clr: simple dual-port RAM (one write, one read port, single clock)
// with byte-lane write enables, registered read, read-during-write forwarding
// and a hardware clear sequencer.
//   clk, rst_n            : clock, asynchronous active-low reset
//   we, wr_addr, wr_data  : external write port (accepted only while idle)
//   wr_be                 : byte enables, bit i covers wr_data[8i+7:8i]
//   re, read_addr         : read request; data appears next cycle
//   read_data, read_valid : registered read data and its valid flag
//   clr_req               : start a clear of the whole array (idle only)
//   clr_busy, clr_done    : clear in progress / one-cycle completion pulse
// Handshake: read_valid is high exactly the cycle after a cycle with re=1;
// there is no back-pressure on either port.
module ram_dp_clr
  import ram_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  input  logic [DATA_WIDTH/LANE_W-1:0] wr_be,
  input  logic                         re,
  input  logic [ADDR_WIDTH-1:0]        read_addr,
  output logic [DATA_WIDTH-1:0]        read_data,
  output logic                         read_valid,
  input  logic                         clr_req,
  output logic                         clr_busy,
  output logic                         clr_done
);

  localparam int LANES = num_lanes(DATA_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (DATA_WIDTH % LANE_W != 0) begin : g_width_check
    $error("ram_dp_clr: DATA_WIDTH must be a multiple of 8");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  clr_state_e            clr_state;

  ram_clear_seq #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_clear_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_req_i  (clr_req),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .clr_busy_o (clr_busy),
    .clr_done_o (clr_done),
    .state_o    (clr_state)
  );

  // Write-port mux: the sequencer owns the port while clearing; external
  // writes are dropped outside IDLE.
  logic                  wp_en;
  logic [ADDR_WIDTH-1:0] wp_addr;
  logic [DATA_WIDTH-1:0] wp_data;
  logic [LANES-1:0]      wp_be;
  logic [DATA_WIDTH-1:0] merged;

  always_comb begin
    wp_en   = 1'b0;
    wp_addr = wr_addr;
    wp_data = wr_data;
    wp_be   = wr_be;
    if (clr_we) begin
      wp_en   = 1'b1;
      wp_addr = clr_addr;
      wp_data = CLEAR_VALUE;
      wp_be   = '1;
    end else if (we && (clr_state == CLR_IDLE)) begin
      wp_en = 1'b1;
    end
  end

  // Merged word: written lanes take new data, others keep the stored value.
  // Used both for the array update and for same-address read forwarding.
  always_comb begin
    merged = mem[wp_addr];
    for (int i = 0; i < LANES; i++) begin
      if (wp_be[i]) merged[i*LANE_W +: LANE_W] = wp_data[i*LANE_W +: LANE_W];
    end
  end

  always_ff @(posedge clk) begin
    if (wp_en) mem[wp_addr] <= merged;
  end

  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  read_valid_q;

  always_comb begin
    read_data_d = read_data_q;
    if (re) begin
      if (wp_en && (wp_addr == read_addr)) read_data_d = merged;
      else                                 read_data_d = mem[read_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      read_data_q  <= read_data_d;
      read_valid_q <= re;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;

endmodule

// File: tb/tb_ram_dp_clr.sv
// tb_ram_dp_clr: directed bench for ram_dp_clr. dut0 uses default parameters,
// dut1 uses ADDR_WIDTH=4 and CLEAR_VALUE=0x55555555 for the clear scenarios.
module tb_ram_dp_clr;

  localparam logic [31:0] CV1 = 32'h5555_5555;

  // clock / reset
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // dut0 signals
  logic        we0, re0, clr_req0;
  logic [7:0]  wr_addr0, rd_addr0;
  logic [31:0] wr_data0, rd_data0;
  logic [3:0]  wr_be0;
  logic        rv0, busy0, done0;

  // dut1 signals
  logic        we1, re1, clr_req1;
  logic [3:0]  wr_addr1, rd_addr1;
  logic [31:0] wr_data1, rd_data1;
  logic [3:0]  wr_be1;
  logic        rv1, busy1, done1;

  ram_dp_clr dut0 (
    .clk (clk), .rst_n (rst_n),
    .we (we0), .wr_addr (wr_addr0), .wr_data (wr_data0), .wr_be (wr_be0),
    .re (re0), .read_addr (rd_addr0), .read_data (rd_data0), .read_valid (rv0),
    .clr_req (clr_req0), .clr_busy (busy0), .clr_done (done0)
  );

  ram_dp_clr #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .CLEAR_VALUE(CV1)) dut1 (
    .clk (clk), .rst_n (rst_n),
    .we (we1), .wr_addr (wr_addr1), .wr_data (wr_data1), .wr_be (wr_be1),
    .re (re1), .read_addr (rd_addr1), .read_data (rd_data1), .read_valid (rv1),
    .clr_req (clr_req1), .clr_busy (busy1), .clr_done (done1)
  );

  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic wr0(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    we0 = 1'b1; wr_addr0 = a; wr_data0 = d; wr_be0 = be;
    step();
    we0 = 1'b0;
  endtask

  task automatic rd0(input string tag, input logic [7:0] a, input logic [31:0] exp);
    re0 = 1'b1; rd_addr0 = a;
    step();
    re0 = 1'b0;
    chk(tag, rd_data0, exp);
    chk({tag, "_valid"}, 32'(rv0), 32'd1);
  endtask

  task automatic wr1(input logic [3:0] a, input logic [31:0] d);
    we1 = 1'b1; wr_addr1 = a; wr_data1 = d; wr_be1 = 4'hF;
    step();
    we1 = 1'b0;
  endtask

  task automatic rd1(input string tag, input logic [3:0] a, input logic [31:0] exp);
    re1 = 1'b1; rd_addr1 = a;
    step();
    re1 = 1'b0;
    chk(tag, rd_data1, exp);
    chk({tag, "_valid"}, 32'(rv1), 32'd1);
  endtask

  initial begin
    int busy_n, done_n, done_at;

    rst_n = 1'b0;
    we0 = 0; re0 = 0; clr_req0 = 0; wr_addr0 = 0; rd_addr0 = 0; wr_data0 = 0; wr_be0 = 0;
    we1 = 0; re1 = 0; clr_req1 = 0; wr_addr1 = 0; rd_addr1 = 0; wr_data1 = 0; wr_be1 = 0;
    step();
    step();

    // reset state
    chk("rst_rd_data0", rd_data0, 32'h0);
    chk("rst_valid0", 32'(rv0), 32'd0);
    chk("rst_busy0", 32'(busy0), 32'd0);
    chk("rst_done0", 32'(done0), 32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    rst_n = 1'b1;
    step();

    // full write then read
    wr0(8'h10, 32'hDEAD_BEEF, 4'hF);
    rd0("rd_full", 8'h10, 32'hDEAD_BEEF);
    step();
    chk("valid_drop", 32'(rv0), 32'd0);
    chk("rd_hold", rd_data0, 32'hDEAD_BEEF);

    // partial lanes 0 and 2
    wr0(8'h10, 32'hAABB_CCDD, 4'b0101);
    rd0("rd_partial", 8'h10, 32'hDEBB_BEDD);

    // same-edge write/read forwarding, full word
    we0 = 1'b1; wr_addr0 = 8'h20; wr_data0 = 32'h1234_5678; wr_be0 = 4'hF;
    re0 = 1'b1; rd_addr0 = 8'h20;
    step();
    we0 = 1'b0; re0 = 1'b0;
    chk("fwd_full", rd_data0, 32'h1234_5678);

    // same-edge forwarding, only lane 3 written
    we0 = 1'b1; wr_addr0 = 8'h10; wr_data0 = 32'h1122_3344; wr_be0 = 4'b1000;
    re0 = 1'b1; rd_addr0 = 8'h10;
    step();
    we0 = 1'b0; re0 = 1'b0;
    chk("fwd_partial", rd_data0, 32'h11BB_BEDD);

    // we with no byte enables changes nothing
    wr0(8'h10, 32'hFFFF_FFFF, 4'h0);
    rd0("be_zero", 8'h10, 32'h11BB_BEDD);
    rd0("rd_20", 8'h20, 32'h1234_5678);

    // clear sequence on dut1
    for (int i = 0; i < 16; i++) wr1(4'(i), 32'hC0DE_0000 + 32'(i));
    rd1("preload9", 4'd9, 32'hC0DE_0009);

    clr_req1 = 1'b1;
    step();
    clr_req1 = 1'b0;
    busy_n = 0; done_n = 0; done_at = -1;
    if (busy1) busy_n++;
    for (int c = 1; c <= 20; c++) begin
      case (c)
        6:  begin re1 = 1'b1; rd_addr1 = 4'd3; end
        7:  begin re1 = 1'b1; rd_addr1 = 4'd6; end
        8:  begin re1 = 1'b1; rd_addr1 = 4'd9; clr_req1 = 1'b1; end
        10: begin we1 = 1'b1; wr_addr1 = 4'd2; wr_data1 = 32'hBAD0_BAD0; wr_be1 = 4'hF; end
        default: ;
      endcase
      step();
      re1 = 1'b0; we1 = 1'b0; clr_req1 = 1'b0;
      if (busy1) busy_n++;
      if (done1) begin done_n++; done_at = c; end
      if (c == 6) chk("clr_rd_below", rd_data1, CV1);
      if (c == 7) chk("clr_rd_fwd", rd_data1, CV1);
      if (c == 8) chk("clr_rd_above", rd_data1, 32'hC0DE_0009);
    end
    chk("clr_busy_cycles", 32'(busy_n), 32'd16);
    chk("clr_done_pulses", 32'(done_n), 32'd1);
    chk("clr_done_cycle", 32'(done_at), 32'd16);
    for (int i = 0; i < 16; i++) rd1($sformatf("clr_word%0d", i), 4'(i), CV1);

    // reset in the middle of a clear
    for (int i = 0; i < 16; i++) wr1(4'(i), 32'h7700_0000 + 32'(i));
    clr_req1 = 1'b1;
    step();
    clr_req1 = 1'b0;
    for (int c = 1; c <= 7; c++) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy1), 32'd0);
    chk("midrst_done", 32'(done1), 32'd0);
    chk("midrst_rd_data", rd_data1, 32'h0);
    chk("midrst_valid", 32'(rv1), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    done_n = 0; busy_n = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (done1) done_n++;
      if (busy1) busy_n++;
    end
    chk("midrst_no_done", 32'(done_n), 32'd0);
    chk("midrst_no_busy", 32'(busy_n), 32'd0);
    for (int i = 0; i < 16; i++)
      rd1($sformatf("partial_word%0d", i), 4'(i), (i < 7) ? CV1 : 32'h7700_0000 + 32'(i));

    // fresh clear after the interrupted one
    clr_req1 = 1'b1;
    step();
    clr_req1 = 1'b0;
    busy_n = 0; done_n = 0;
    if (busy1) busy_n++;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (busy1) busy_n++;
      if (done1) done_n++;
    end
    chk("reclr_busy_cycles", 32'(busy_n), 32'd16);
    chk("reclr_done_pulses", 32'(done_n), 32'd1);
    rd1("reclr_w0", 4'd0, CV1);
    rd1("reclr_w7", 4'd7, CV1);
    rd1("reclr_w15", 4'd15, CV1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
